hc_secded_pipe: RTL and testbench

Parametrised, pipelined SECDED (single-error-correct, double-error-detect) Hamming codec. Encodes DATA_W-bit words, optionally injects a per-word error pattern, then decodes and corrects. Valid/ready handshakes on both sides and saturating error counters. Successor to the fixed 4-bit combinational encoder/decoder pair; it sits on datapaths and memory-test harnesses that need ECC with backpressure.

---
 rtl/hc_secded_pipe.sv | 151 +++++++++++++++
 tb/tb_hc_secded_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_secded_pipe.sv
// ============================================================================
//  Module      : hc_secded_pipe
//  Description : Two-stage pipelined SECDED Hamming codec with optional
//                per-word error injection, valid/ready flow control and
//                saturating single/double error counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hc_secded_pipe #(
    parameter  int DATA_W = 4,
    parameter  int CNT_W  = 16,
    localparam int P      = (DATA_W <= 4)  ? 3 :
                            (DATA_W <= 11) ? 4 :
                            (DATA_W <= 26) ? 5 :
                            (DATA_W <= 57) ? 6 : 7,
    localparam int CW     = DATA_W + P + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_inj_en,
    input  logic [CW-1:0]     i_err_mask,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_sbe,
    output logic              o_dbe,
    output logic [P-1:0]      o_syndrome,
    input  logic              i_cnt_clr,
    output logic [CNT_W-1:0]  o_sbe_cnt,
    output logic [CNT_W-1:0]  o_dbe_cnt
);

    // Data bits fill the non-power-of-two Hamming positions in ascending order.
    function automatic logic [CW-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CW-1:0]     cw;
        logic [DATA_W-1:0] ds;
        logic              pbit;
        cw = '0;
        ds = d;
        for (int k = 1; k < CW; k++) begin
            if ((k & (k - 1)) != 0) begin
                cw[k] = ds[0];
                ds    = ds >> 1;
            end
        end
        for (int j = 0; j < P; j++) begin
            pbit = 1'b0;
            for (int k = 1; k < CW; k++) begin
                if (((k >> j) & 1) == 1) pbit = pbit ^ cw[k];
            end
            cw[1 << j] = pbit;
        end
        cw[0] = ^cw[CW-1:1];
        return cw;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CW-1:0] cw);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int k = 1; k < CW; k++) begin
            if ((k & (k - 1)) != 0) d = {cw[k], d[DATA_W-1:1]};
        end
        return d;
    endfunction

    logic              s1_valid;
    logic [CW-1:0]     s1_cw;
    logic              s1_adv;
    logic              s2_adv;

    logic [P-1:0]      dec_syn;
    logic              dec_par;
    logic [CW-1:0]     dec_cw;
    logic              dec_sbe;
    logic              dec_dbe;
    logic [DATA_W-1:0] dec_data;

    assign s2_adv  = !o_valid || i_ready;
    assign s1_adv  = !s1_valid || s2_adv;
    assign o_ready = s1_adv && !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_cw    <= '0;
        end else if (s1_adv) begin
            s1_valid <= i_valid;
            if (i_valid) s1_cw <= encode(i_data) ^ (i_inj_en ? i_err_mask : '0);
        end
    end

    always_comb begin
        dec_syn = '0;
        for (int k = 1; k < CW; k++) begin
            if (s1_cw[k]) dec_syn = dec_syn ^ P'(k);
        end
        dec_par = ^s1_cw;
        dec_cw  = s1_cw;
        dec_sbe = 1'b0;
        dec_dbe = 1'b0;
        if (dec_par) begin
            if (dec_syn == '0) begin
                dec_sbe = 1'b1;
            end else if (int'(dec_syn) < CW) begin
                dec_cw  = s1_cw ^ (CW'(1) << dec_syn);
                dec_sbe = 1'b1;
            end else begin
                dec_dbe = 1'b1;
            end
        end else if (dec_syn != '0) begin
            dec_dbe = 1'b1;
        end
        dec_data = extract(dec_cw);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_sbe      <= 1'b0;
            o_dbe      <= 1'b0;
            o_syndrome <= '0;
        end else if (s2_adv) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_data     <= dec_data;
                o_sbe      <= dec_sbe;
                o_dbe      <= dec_dbe;
                o_syndrome <= dec_syn;
            end
        end
    end

    // Clear takes priority over a coincident delivery, which goes uncounted.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_cnt_clr) begin
            o_sbe_cnt <= '0;
            o_dbe_cnt <= '0;
        end else if (o_valid && i_ready) begin
            if (o_sbe && !(&o_sbe_cnt)) o_sbe_cnt <= o_sbe_cnt + 1'b1;
            if (o_dbe && !(&o_dbe_cnt)) o_dbe_cnt <= o_dbe_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hc_secded_pipe.sv
// ============================================================================
//  Module      : tb_hc_secded_pipe
//  Description : Scoreboard bench for hc_secded_pipe (DATA_W=4, CNT_W=2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hc_secded_pipe;

    logic       clk;
    logic       i_rst;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] i_data;
    logic       i_inj_en;
    logic [7:0] i_err_mask;
    logic       o_valid;
    logic       i_ready;
    logic [3:0] o_data;
    logic       o_sbe;
    logic       o_dbe;
    logic [2:0] o_syndrome;
    logic       i_cnt_clr;
    logic [1:0] o_sbe_cnt;
    logic [1:0] o_dbe_cnt;

    hc_secded_pipe #(.DATA_W(4), .CNT_W(2)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .i_inj_en   (i_inj_en),
        .i_err_mask (i_err_mask),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_sbe      (o_sbe),
        .o_dbe      (o_dbe),
        .o_syndrome (o_syndrome),
        .i_cnt_clr  (i_cnt_clr),
        .o_sbe_cnt  (o_sbe_cnt),
        .o_dbe_cnt  (o_dbe_cnt)
    );

    typedef struct packed {
        logic [3:0] d;
        logic       sbe;
        logic       dbe;
        logic [2:0] syn;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   delivered = 0;
    bit   rand_rdy = 1'b0;
    bit   prev_stall = 1'b0;
    logic [9:0] snap = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] d, input logic sbe, input logic dbe,
                                input logic [2:0] syn);
        exp_t e;
        e.d = d; e.sbe = sbe; e.dbe = dbe; e.syn = syn;
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        if (rand_rdy) i_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: pops the scoreboard on each output handshake; checks hold while stalled.
    always @(negedge clk) begin
        if (i_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", 32'({o_valid, o_data, o_sbe, o_dbe, o_syndrome}), 32'(snap));
            if (o_valid && i_ready) begin
                delivered++;
                if (q.size() == 0) begin
                    check("unexpected_output", 32'(o_valid), 32'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("o_data", 32'(o_data), 32'(e.d));
                    check("o_sbe", 32'(o_sbe), 32'(e.sbe));
                    check("o_dbe", 32'(o_dbe), 32'(e.dbe));
                    check("o_syndrome", 32'(o_syndrome), 32'(e.syn));
                end
            end
            prev_stall = o_valid && !i_ready;
            snap = {o_valid, o_data, o_sbe, o_dbe, o_syndrome};
        end
    end

    // Called in the posedge+1 phase; returns in the same phase after acceptance.
    task automatic send(input logic [3:0] d, input logic inj, input logic [7:0] m, input exp_t e);
        int n  = 0;
        bit ok = 1'b0;
        i_valid = 1'b1; i_data = d; i_inj_en = inj; i_err_mask = m;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (o_ready) ok = 1'b1;
            n++;
        end
        if (!ok) begin
            check("accept_timeout", 32'(0), 32'(1));
        end else begin
            q.push_back(e);
        end
        @(posedge clk); #1;
        i_valid = 1'b0; i_inj_en = 1'b0; i_err_mask = '0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_left", 32'(q.size()), 32'(0));
        q.delete();
    endtask

    initial begin
        int n;
        int base;
        i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_inj_en = 1'b0;
        i_err_mask = '0; i_ready = 1'b1; i_cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_o_ready", 32'(o_ready), 32'(0));
        check("rst_o_valid", 32'(o_valid), 32'(0));
        check("rst_o_data", 32'(o_data), 32'(0));
        check("rst_o_syndrome", 32'(o_syndrome), 32'(0));
        check("rst_flags", 32'({o_sbe, o_dbe}), 32'(0));
        check("rst_cnts", 32'({o_sbe_cnt, o_dbe_cnt}), 32'(0));
        i_rst = 1'b0;
        @(negedge clk);
        check("o_ready_after_rst", 32'(o_ready), 32'(1));
        @(posedge clk); #1;

        // Clean word and two-cycle latency
        send(4'hB, 1'b0, 8'h00, mk(4'hB, 1'b0, 1'b0, 3'd0));
        check("latency_n1", 32'(o_valid), 32'(0));
        @(posedge clk); #1;
        check("latency_n2", 32'(o_valid), 32'(1));
        drain();

        send(4'hB, 1'b1, 8'h20, mk(4'hB, 1'b1, 1'b0, 3'd5));
        drain();
        check("sbe_cnt_1", 32'(o_sbe_cnt), 32'(1));

        send(4'hB, 1'b1, 8'h01, mk(4'hB, 1'b1, 1'b0, 3'd0));
        send(4'hB, 1'b1, 8'h21, mk(4'h9, 1'b0, 1'b1, 3'd5));
        drain();
        check("sbe_cnt_2", 32'(o_sbe_cnt), 32'(2));
        check("dbe_cnt_1", 32'(o_dbe_cnt), 32'(1));

        // Mask with inj_en low must be ignored
        send(4'h3, 1'b0, 8'hFF, mk(4'h3, 1'b0, 1'b0, 3'd0));
        // Two flipped parity positions 1 and 2: syndrome 3, data untouched
        send(4'h0, 1'b1, 8'h06, mk(4'h0, 1'b0, 1'b1, 3'd3));
        drain();
        check("dbe_cnt_2", 32'(o_dbe_cnt), 32'(2));

        // Stream 0..F with random downstream backpressure
        base = delivered;
        rand_rdy = 1'b1;
        for (int i = 0; i < 16; i++)
            send(4'(i), 1'b0, 8'h00, mk(4'(i), 1'b0, 1'b0, 3'd0));
        drain();
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        i_ready = 1'b1;
        check("stream_count", 32'(delivered - base), 32'(16));

        // Full pipeline stalls the input, resumes combinationally
        i_ready = 1'b0;
        send(4'hB, 1'b1, 8'h02, mk(4'hB, 1'b1, 1'b0, 3'd1));
        send(4'h6, 1'b0, 8'h00, mk(4'h6, 1'b0, 1'b0, 3'd0));
        @(negedge clk);
        check("bp_o_ready_low", 32'(o_ready), 32'(0));
        repeat (3) @(posedge clk);
        #1;
        i_ready = 1'b1;
        @(negedge clk);
        check("bp_o_ready_resume", 32'(o_ready), 32'(1));
        @(posedge clk); #1;
        drain();
        check("sbe_cnt_3", 32'(o_sbe_cnt), 32'(3));

        // Five more SBE words: counter saturates at 3
        send(4'h0, 1'b1, 8'h02, mk(4'h0, 1'b1, 1'b0, 3'd1));
        send(4'h5, 1'b1, 8'h04, mk(4'h5, 1'b1, 1'b0, 3'd2));
        send(4'hF, 1'b1, 8'h08, mk(4'hF, 1'b1, 1'b0, 3'd3));
        send(4'h3, 1'b1, 8'h40, mk(4'h3, 1'b1, 1'b0, 3'd6));
        send(4'hC, 1'b1, 8'h80, mk(4'hC, 1'b1, 1'b0, 3'd7));
        drain();
        check("sbe_cnt_sat", 32'(o_sbe_cnt), 32'(3));

        // Clear coincident with an SBE delivery
        i_ready = 1'b0;
        send(4'hB, 1'b1, 8'h20, mk(4'hB, 1'b1, 1'b0, 3'd5));
        n = 0;
        while (!o_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("clr_o_valid", 32'(o_valid), 32'(1));
        i_ready = 1'b1; i_cnt_clr = 1'b1;
        @(posedge clk); #1;
        i_cnt_clr = 1'b0;
        check("clr_sbe_cnt", 32'(o_sbe_cnt), 32'(0));
        check("clr_dbe_cnt", 32'(o_dbe_cnt), 32'(0));
        drain();

        // Reset mid-stream discards in-flight words and clears counters
        send(4'h7, 1'b1, 8'h10, mk(4'h7, 1'b1, 1'b0, 3'd4));
        drain();
        check("pre_rst_sbe_cnt", 32'(o_sbe_cnt), 32'(1));
        i_ready = 1'b0;
        send(4'h1, 1'b0, 8'h00, mk(4'h1, 1'b0, 1'b0, 3'd0));
        send(4'h2, 1'b0, 8'h00, mk(4'h2, 1'b0, 1'b0, 3'd0));
        q.delete();
        i_rst = 1'b1;
        @(negedge clk);
        check("midrst_o_ready", 32'(o_ready), 32'(0));
        @(posedge clk); #1;
        check("midrst_o_valid", 32'(o_valid), 32'(0));
        check("midrst_sbe_cnt", 32'(o_sbe_cnt), 32'(0));
        i_rst = 1'b0;
        i_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(o_valid), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
